// File: rtl/dma_pkg.sv
// Shared definitions for the DMA / processor memory arbiter: FSM encoding,
// bus-owner tags and the per-word address step.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    LEER     = 3'd2,
    ESCRIBIR = 3'd3,
    FIN      = 3'd4
  } estado_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam int unsigned WORD_INC = 4;

endpackage

// File: rtl/dma_contador_dir.sv
// Source/destination address and remaining-length registers for one DMA
// transfer; loaded on start, stepped once per moved word.
module dma_contador_dir
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  len,
  output logic              ultimo_word
);

  // NOTE: registers are written with <= so every reader in the same edge
  // sees the pre-edge value, regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      src <= '0;
      dst <= '0;
      len <= '0;
    end else if (load) begin
      src <= src_in;
      dst <= dst_in;
      len <= len_in;
    end else if (step) begin
      // Address add wraps naturally at 2^ADDR_W; length saturates at zero.
      src <= src + ADDR_W'(WORD_INC);
      dst <= dst + ADDR_W'(WORD_INC);
      if (len != '0) len <= len - LEN_W'(1);
    end
  end

  assign ultimo_word = (len == LEN_W'(1));

endmodule

// File: rtl/arbitro_dma_memoria.sv
// Shares the single-port data memory between the processor and a
// cycle-stealing DMA copier; the processor is stalled only during a word move.
module arbitro_dma_memoria
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [LEN_W-1:0]  dma_len,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  estado_t           estado, estado_sig;
  owner_t            ultimo, ultimo_sig;
  logic              load, step;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  len;
  logic              ultimo_word;

  dma_contador_dir #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_contador (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .src_in      (dma_src),
    .dst_in      (dma_dst),
    .len_in      (dma_len),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .ultimo_word (ultimo_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= IDLE;
      ultimo <= OWN_CPU;
    end else begin
      estado <= estado_sig;
      ultimo <= ultimo_sig;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    estado_sig = estado;
    ultimo_sig = ultimo;
    load       = 1'b0;
    step       = 1'b0;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_we     = cpu_we & cpu_mem_req;
    cpu_stall  = 1'b0;
    dma_busy   = 1'b0;
    dma_done   = 1'b0;

    unique case (estado)
      IDLE: begin
        if (dma_start) begin
          if (dma_len != '0) begin
            load       = 1'b1;
            ultimo_sig = OWN_CPU;
            estado_sig = ARB;
          end else begin
            estado_sig = FIN;
          end
        end
      end
      ARB: begin
        dma_busy = 1'b1;
        // Processor keeps the bus whenever the DMA moved the previous word.
        if (cpu_mem_req && ultimo == OWN_DMA) ultimo_sig = OWN_CPU;
        else                                  estado_sig = LEER;
      end
      LEER: begin
        dma_busy   = 1'b1;
        mem_addr   = src;
        mem_we     = 1'b0;
        cpu_stall  = cpu_mem_req;
        estado_sig = ESCRIBIR;
      end
      ESCRIBIR: begin
        dma_busy   = 1'b1;
        mem_addr   = dst;
        mem_wdata  = mem_rdata;
        mem_we     = 1'b1;
        cpu_stall  = cpu_mem_req;
        step       = 1'b1;
        ultimo_sig = OWN_DMA;
        estado_sig = ultimo_word ? FIN : ARB;
      end
      FIN: begin
        dma_done   = 1'b1;
        estado_sig = IDLE;
      end
      default: estado_sig = IDLE;
    endcase

    // While reset is asserted the bus is a write-inhibited pass-through.
    if (reset) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = 1'b0;
      cpu_stall = 1'b0;
      dma_busy  = 1'b0;
      dma_done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_arbitro_dma_memoria.sv
// Self-checking bench: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed cycle counts and memory contents.
module tb_arbitro_dma_memoria;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_req, cpu_we, dma_start;
  logic [31:0] cpu_addr, cpu_wdata, dma_src, dma_dst;
  logic [7:0]  dma_len;
  logic        cpu_stall, dma_busy, dma_done, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  bit [31:0] mem     [bit [29:0]];
  bit [31:0] ref_mem [bit [29:0]];

  arbitro_dma_memoria #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_mem_req (cpu_mem_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_stall   (cpu_stall),
    .dma_start   (dma_start),
    .dma_src     (dma_src),
    .dma_dst     (dma_dst),
    .dma_len     (dma_len),
    .dma_busy    (dma_busy),
    .dma_done    (dma_done),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] rd_mem(input bit [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return 32'h0;
  endfunction

  function automatic bit [31:0] rd_ref(input bit [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return 32'h0;
  endfunction

  // Synchronous-read single-port memory, read-before-write.
  always @(posedge clk) begin
    mem_rdata <= rd_mem(mem_addr);
    if (mem_we) mem[mem_addr[31:2]] = mem_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input bit [31:0] a, input bit [31:0] d);
    mem[a[31:2]]     = d;
    ref_mem[a[31:2]] = d;
  endtask

  // Model: a started transfer is a queue of (src,dst) word moves; each move
  // is an arbitration slot, a read slot and a write slot. The processor is
  // owed one slot after every DMA write.
  bit        m_active = 1'b0;
  bit        m_done   = 1'b0;
  bit        m_cpu_turn = 1'b0;
  int        m_phase  = 0;
  bit [31:0] m_src_q[$];
  bit [31:0] m_dst_q[$];

  always @(negedge clk) begin : cmp
    bit        e_busy, e_done, e_stall, e_we, pass;
    bit [31:0] e_addr, e_wdata;
    pass    = 1'b1;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    e_stall = 1'b0;
    e_addr  = cpu_addr;
    e_wdata = cpu_wdata;
    e_we    = cpu_we & cpu_mem_req;
    if (reset) e_we = 1'b0;
    else if (m_done) e_done = 1'b1;
    else if (m_active) begin
      e_busy = 1'b1;
      if (m_phase == 1) begin
        pass = 1'b0; e_addr = m_src_q[0]; e_we = 1'b0; e_stall = cpu_mem_req;
      end else if (m_phase == 2) begin
        pass = 1'b0; e_addr = m_dst_q[0]; e_we = 1'b1; e_stall = cpu_mem_req;
        e_wdata = rd_ref(m_src_q[0]);
      end
    end

    check("dma_busy", dma_busy, e_busy);
    check("dma_done", dma_done, e_done);
    check("cpu_stall", cpu_stall, e_stall);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    if (e_we) check("mem_wdata", mem_wdata, e_wdata);

    if (reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_src_q.delete();
      m_dst_q.delete();
    end else begin
      if (pass && e_we) ref_mem[cpu_addr[31:2]] = cpu_wdata;
      if (m_done) m_done = 1'b0;
      else if (m_active) begin
        if (m_phase == 0) begin
          if (cpu_mem_req && m_cpu_turn) m_cpu_turn = 1'b0;
          else m_phase = 1;
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else begin
          ref_mem[m_dst_q[0][31:2]] = e_wdata;
          void'(m_src_q.pop_front());
          void'(m_dst_q.pop_front());
          m_cpu_turn = 1'b1;
          m_phase    = 0;
          if (m_src_q.size() == 0) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end else if (dma_start) begin
        if (dma_len == 8'd0) m_done = 1'b1;
        else begin
          for (int i = 0; i < int'(dma_len); i++) begin
            m_src_q.push_back(dma_src + 32'(4 * i));
            m_dst_q.push_back(dma_dst + 32'(4 * i));
          end
          m_active   = 1'b1;
          m_phase    = 0;
          m_cpu_turn = 1'b0;
        end
      end
    end
  end

  // Start a transfer with no processor traffic; report the cycle of dma_done
  // (counted from the start cycle) and how many cycles dma_busy was high.
  task automatic run_copy(input bit [31:0] s, input bit [31:0] d, input bit [7:0] n,
                          output int done_at, output int busy_cnt);
    dma_src = s; dma_dst = d; dma_len = n; dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    done_at  = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 60 && done_at < 0; k++) begin
      if (dma_busy) busy_cnt++;
      if (dma_done) done_at = k;
      tick();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int done_at, busy_cnt, n_st, stalls, run, maxrun, done_cnt;
    reset = 1'b1; dma_start = 1'b0; dma_src = '0; dma_dst = '0; dma_len = '0;
    cpu_mem_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'hDEAD_BEEF;
    tick();
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_busy", dma_busy, 1'b0);
    check("rst_stall", cpu_stall, 1'b0);
    tick();
    reset = 1'b0; cpu_mem_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("rst_no_store", rd_mem(32'h44), 32'h0);

    // Idle pass-through store
    cpu_mem_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hA5A5_A5A5;
    #1;
    check("idle_we", mem_we, 1'b1);
    check("idle_addr", mem_addr, 32'h40);
    check("idle_stall", cpu_stall, 1'b0);
    tick();
    cpu_mem_req = 1'b0; cpu_we = 1'b0;
    check("idle_mem", rd_mem(32'h40), 32'hA5A5_A5A5);

    // Basic copy, no processor traffic
    for (int i = 0; i < 4; i++) poke(32'h100 + 32'(4 * i), 32'(i + 1));
    run_copy(32'h100, 32'h200, 8'd4, done_at, busy_cnt);
    check("copy_done_cycle", done_at, 13);
    check("copy_busy_cycles", busy_cnt, 12);
    for (int i = 0; i < 4; i++) check("copy_data", rd_mem(32'h200 + 32'(4 * i)), 32'(i + 1));

    // Contention: processor stores every cycle it is not stalled
    for (int i = 0; i < 4; i++) poke(32'h500 + 32'(4 * i), 32'(17 * (i + 1)));
    dma_src = 32'h500; dma_dst = 32'h700; dma_len = 8'd4; dma_start = 1'b1;
    tick();
    dma_start = 1'b0; cpu_mem_req = 1'b1; cpu_we = 1'b1;
    n_st = 0; stalls = 0; run = 0; maxrun = 0; done_at = -1;
    for (int k = 1; k <= 60 && done_at < 0; k++) begin
      cpu_addr  = 32'h800 + 32'(4 * n_st);
      cpu_wdata = 32'hC000_0000 | 32'(n_st);
      #1;
      if (cpu_stall) begin
        stalls++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0; n_st++;
      end
      if (dma_done) done_at = k;
      tick();
    end
    cpu_mem_req = 1'b0; cpu_we = 1'b0;
    check("cont_done_cycle", done_at, 16);
    check("cont_stalls", stalls, 8);
    check("cont_max_stall_run", maxrun, 2);
    check("cont_cpu_stores", n_st, 8);
    for (int i = 0; i < 4; i++) check("cont_copy", rd_mem(32'h700 + 32'(4 * i)), 32'(17 * (i + 1)));
    for (int i = 0; i < n_st; i++)
      check("cont_store", rd_mem(32'h800 + 32'(4 * i)), 32'hC000_0000 | 32'(i));

    // Zero length
    dma_len = 8'd0; dma_src = 32'h100; dma_dst = 32'hB00; dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    check("zero_done", dma_done, 1'b1);
    check("zero_busy", dma_busy, 1'b0);
    check("zero_we", mem_we, 1'b0);
    tick();
    check("zero_done_clear", dma_done, 1'b0);

    // Start pulses while busy and in FIN are ignored
    poke(32'h900, 32'h99); poke(32'h904, 32'h98);
    dma_src = 32'h100; dma_dst = 32'h600; dma_len = 8'd2; dma_start = 1'b1;
    tick();
    done_at = -1;
    for (int k = 1; k <= 30 && done_at < 0; k++) begin
      if (k == 3 || k == 7) begin
        dma_start = 1'b1; dma_src = 32'h900; dma_dst = 32'h940; dma_len = 8'd5;
      end else begin
        dma_start = 1'b0;
      end
      #1;
      if (dma_done) done_at = k;
      tick();
    end
    dma_start = 1'b0;
    #1;
    check("ign_done_cycle", done_at, 7);
    check("ign_after_fin_busy", dma_busy, 1'b0);
    check("ign_after_fin_done", dma_done, 1'b0);
    check("ign_copy0", rd_mem(32'h600), 32'h1);
    check("ign_copy1", rd_mem(32'h604), 32'h2);
    check("ign_untouched", rd_mem(32'h940), 32'h0);
    tick();

    // Address wrap-around
    poke(32'hFFFF_FFF8, 32'hAAA1); poke(32'hFFFF_FFFC, 32'hAAA2); poke(32'h0, 32'hAAA3);
    run_copy(32'hFFFF_FFF8, 32'h300, 8'd3, done_at, busy_cnt);
    check("wrap_done_cycle", done_at, 10);
    check("wrap_w0", rd_mem(32'h300), 32'hAAA1);
    check("wrap_w1", rd_mem(32'h304), 32'hAAA2);
    check("wrap_w2", rd_mem(32'h308), 32'hAAA3);

    // Reset during the write of word 2
    dma_src = 32'h100; dma_dst = 32'hA00; dma_len = 8'd4; dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    repeat (5) tick();
    check("mid_in_write", mem_we, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_we", mem_we, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_busy", dma_busy, 1'b0);
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (dma_done) done_cnt++;
      tick();
    end
    check("mid_no_done", done_cnt, 0);
    check("mid_word1", rd_mem(32'hA00), 32'h1);
    check("mid_word2", rd_mem(32'hA04), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
